// File: rtl/pc_unit.sv
`timescale 1ns/1ps
// pc_unit: fetch program-counter generator.
//   Presents a fetch address (pc_out/pc_valid) to the fetch side and advances
//   it by 4 on each accepted handshake. Trap and redirect requests retarget the
//   PC. A request that arrives while fetch is stalled is parked in a single
//   pending entry until the next handshake. Misaligned targets are dropped and
//   reported for one cycle.
// Ports:
//   clk, reset                        clock, async active-high reset
//   redirect_valid/redirect_target    branch/jump redirect request
//   trap_valid/trap_vector            trap redirect request
//   fetch_ready                       fetch side accepts pc_out this cycle
//   pc_out/pc_valid                   current fetch request
//   misalign_err/misalign_addr        rejected-target pulse and its address
//   fetch_count                       completed handshakes (wrapping)
module pc_unit #(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
    parameter int unsigned          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_vector,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  pc_out,
    output logic             pc_valid,
    output logic             misalign_err,
    output logic [XLEN-1:0]  misalign_addr,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pend_addr;
    logic            pend_valid;
    logic            pend_trap;

    logic            trap_ok;
    logic            trap_bad;
    logic            redir_ok;
    logic            redir_bad;
    logic            redir_wins;
    logic            handshake;
    logic            stall;
    logic [XLEN-1:0] next_pc;

    always_comb begin
        trap_ok    = trap_valid     && (trap_vector[1:0] == 2'b00);
        trap_bad   = trap_valid     && (trap_vector[1:0] != 2'b00);
        redir_ok   = redirect_valid && (redirect_target[1:0] == 2'b00);
        redir_bad  = redirect_valid && (redirect_target[1:0] != 2'b00);
        // A redirect never displaces a parked trap, neither in the entry
        // itself nor when choosing the address on the releasing handshake.
        redir_wins = redir_ok && !(pend_valid && pend_trap);
        handshake  = pc_valid && fetch_ready;
        stall      = pc_valid && !fetch_ready;

        next_pc = pc_out;
        if (state == BOOT) begin
            // Boot keeps RESET_VECTOR as the first fetch unless a request
            // replaces it; there is no sequential advance before first fetch.
            if (trap_ok)
                next_pc = trap_vector;
            else if (redir_ok)
                next_pc = redirect_target;
        end else if (handshake) begin
            if (trap_ok)
                next_pc = trap_vector;
            else if (redir_wins)
                next_pc = redirect_target;
            else if (pend_valid)
                next_pc = pend_addr;
            else
                next_pc = pc_out + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= BOOT;
            pc_out        <= RESET_VECTOR;
            pc_valid      <= 1'b0;
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
            fetch_count   <= '0;
            pend_addr     <= '0;
            pend_valid    <= 1'b0;
            pend_trap     <= 1'b0;
        end else begin
            pc_out <= next_pc;

            misalign_err <= trap_bad || redir_bad;
            if (trap_bad)
                misalign_addr <= trap_vector;
            else if (redir_bad)
                misalign_addr <= redirect_target;

            if (handshake)
                fetch_count <= fetch_count + CNT_W'(1);

            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN, HOLD: begin
                    pc_valid <= 1'b1;
                    if (handshake) begin
                        pend_valid <= 1'b0;
                        pend_trap  <= 1'b0;
                        state      <= RUN;
                    end else if (stall) begin
                        if (trap_ok) begin
                            pend_addr  <= trap_vector;
                            pend_trap  <= 1'b1;
                            pend_valid <= 1'b1;
                            state      <= HOLD;
                        end else if (redir_wins) begin
                            pend_addr  <= redirect_target;
                            pend_trap  <= 1'b0;
                            pend_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
`timescale 1ns/1ps
// tb_pc_unit: directed stimulus for pc_unit with a queue-based scoreboard.
// Stimulus pushes the expected fetch address/count for each handshake and the
// expected address for each misalign pulse; a negedge monitor pops and compares.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        fetch_ready;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        misalign_err;
    logic [31:0] misalign_addr;
    logic [3:0]  fetch_count;

    pc_unit #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_1000),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .trap_valid(trap_valid),
        .trap_vector(trap_vector),
        .fetch_ready(fetch_ready),
        .pc_out(pc_out),
        .pc_valid(pc_valid),
        .misalign_err(misalign_err),
        .misalign_addr(misalign_addr),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0]  exp_pc_q[$];
    int unsigned  exp_cnt_q[$];
    logic [31:0]  exp_mis_q[$];
    int unsigned  cnt_m = 0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc    = '0;
    logic [31:0] mon_pc;
    int unsigned mon_cnt;
    logic [31:0] mon_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%0h with no expectation queued", name, act);
    endtask

    task automatic expect_hs(input logic [31:0] pc);
        exp_pc_q.push_back(pc);
        exp_cnt_q.push_back(cnt_m);
        cnt_m = (cnt_m + 1) % 16;
    endtask

    task automatic expect_mis(input logic [31:0] addr);
        exp_mis_q.push_back(addr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (pc_valid && fetch_ready) begin
                if (exp_pc_q.size() == 0) begin
                    unexpected("handshake", pc_out);
                end else begin
                    mon_pc  = exp_pc_q.pop_front();
                    mon_cnt = exp_cnt_q.pop_front();
                    chk("hs_pc", pc_out, mon_pc);
                    chk("hs_count", 32'(fetch_count), mon_cnt);
                end
            end
            if (misalign_err) begin
                if (exp_mis_q.size() == 0) begin
                    unexpected("misalign_err", misalign_addr);
                end else begin
                    mon_mis = exp_mis_q.pop_front();
                    chk("misalign_addr", misalign_addr, mon_mis);
                end
            end
            if (prev_stall && pc_valid)
                chk("stall_hold", pc_out, prev_pc);
            prev_stall = pc_valid && !fetch_ready;
            prev_pc    = pc_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        trap_valid      = 1'b0;
        trap_vector     = '0;
        fetch_ready     = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_pc", pc_out, 32'h1000);
        chk("rst_valid", 32'(pc_valid), 0);
        chk("rst_err", 32'(misalign_err), 0);
        chk("rst_maddr", misalign_addr, 0);
        chk("rst_count", 32'(fetch_count), 0);

        // Boot then sequential fetch
        reset = 1'b0;
        fetch_ready = 1'b1;
        tick();                                  // BOOT cycle, no handshake
        expect_hs(32'h1000); tick();
        expect_hs(32'h1004); tick();
        expect_hs(32'h1008); tick();

        // Stalled redirect parked until handshake
        redirect_valid = 1'b1; redirect_target = 32'h2000;
        expect_hs(32'h100C); tick();
        redirect_valid = 1'b0; fetch_ready = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_target = 32'h3000;
        tick();
        redirect_valid = 1'b0;
        tick(); tick(); tick();
        fetch_ready = 1'b1;
        expect_hs(32'h2000); tick();
        expect_hs(32'h3000); tick();

        // Trap beats redirect in the same cycle
        trap_valid = 1'b1; trap_vector = 32'h80;
        redirect_valid = 1'b1; redirect_target = 32'h400;
        expect_hs(32'h3004); tick();
        trap_valid = 1'b0; redirect_valid = 1'b0;
        expect_hs(32'h80); tick();

        // Pending trap survives a later redirect
        fetch_ready = 1'b0;
        trap_valid = 1'b1; trap_vector = 32'h80;
        tick();
        trap_valid = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h400;
        tick();
        redirect_valid = 1'b0;
        tick();
        fetch_ready = 1'b1;
        expect_hs(32'h84); tick();
        expect_hs(32'h80); tick();

        // Misaligned redirect dropped, then both misaligned (trap recorded)
        redirect_valid = 1'b1; redirect_target = 32'h1002;
        expect_hs(32'h84); expect_mis(32'h1002); tick();
        redirect_valid = 1'b0;
        expect_hs(32'h88); tick();
        trap_valid = 1'b1; trap_vector = 32'h81;
        redirect_valid = 1'b1; redirect_target = 32'h402;
        expect_hs(32'h8C); expect_mis(32'h81); tick();
        trap_valid = 1'b0; redirect_valid = 1'b0;
        expect_hs(32'h90); tick();

        // Address wrap and fetch_count wrap (15 -> 0)
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        expect_hs(32'h94); tick();
        redirect_valid = 1'b0;
        expect_hs(32'hFFFF_FFFC); tick();
        expect_hs(32'h0); tick();

        // Reset during HOLD discards pending redirect; reset acts without a clock
        fetch_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h500;
        tick();
        redirect_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_pc", pc_out, 32'h1000);
        chk("async_valid", 32'(pc_valid), 0);
        chk("async_maddr", misalign_addr, 0);
        chk("async_count", 32'(fetch_count), 0);
        cnt_m = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        fetch_ready = 1'b1;
        tick();
        expect_hs(32'h1000); tick();
        expect_hs(32'h1004); tick();

        // Trap during BOOT replaces RESET_VECTOR; pending trap beats new redirect
        reset = 1'b1;
        tick();
        cnt_m = 0;
        reset = 1'b0;
        trap_valid = 1'b1; trap_vector = 32'h200;
        tick();
        trap_valid = 1'b0;
        expect_hs(32'h200); tick();
        fetch_ready = 1'b0;
        trap_valid = 1'b1; trap_vector = 32'h600;
        tick();
        trap_valid = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h700;
        fetch_ready = 1'b1;
        expect_hs(32'h204); tick();
        redirect_valid = 1'b0;
        expect_hs(32'h600); tick();
        fetch_ready = 1'b0;
        tick(); tick();

        chk("pc_queue_drained", 32'(exp_pc_q.size()), 0);
        chk("mis_queue_drained", 32'(exp_mis_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the PC and target width in bits (legal values: 32 or 64).
REQ-002 SHALL have parameter RESET_VECTOR, default 0, meaning the PC value loaded on reset.
REQ-003 SHALL have parameter CNT_W, default 32, meaning the width of the fetch-handshake counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-007 SHALL have port redirect_target, input, XLEN bits: redirect destination.
REQ-008 SHALL have port trap_valid, input, 1 bit: trap redirect request.
REQ-009 SHALL have port trap_vector, input, XLEN bits: trap destination.
REQ-010 SHALL have port fetch_ready, input, 1 bit: the fetch side accepts pc_out this cycle.
REQ-011 SHALL have port pc_out, output, XLEN bits: current fetch address.
REQ-012 SHALL have port pc_valid, output, 1 bit: pc_out is a valid fetch request.
REQ-013 SHALL have port misalign_err, output, 1 bit: one-cycle pulse when a target is rejected.
REQ-014 SHALL have port misalign_addr, output, XLEN bits: last rejected target.
REQ-015 SHALL have port fetch_count, output, CNT_W bits: number of completed handshakes.

Function
REQ-016 The FSM SHALL have three states: BOOT, RUN and HOLD.
REQ-017 The block SHALL leave BOOT for RUN unconditionally after one cycle; pc_valid=0 in BOOT and pc_valid=1 in RUN and HOLD.
REQ-018 A handshake SHALL occur on any cycle where pc_valid=1 and fetch_ready=1.
REQ-019 pc_out SHALL remain stable while pc_valid=1 and fetch_ready=0.
REQ-020 A request (trap or redirect) is aligned when target[1:0]=0. A misaligned request SHALL be dropped, and on the next cycle misalign_err=1 and misalign_addr=target.
  - When both requests in a cycle are misaligned, misalign_addr SHALL record trap_vector.
REQ-021 Next-PC priority on a handshake cycle, or in BOOT (no handshake required in BOOT):
  - 1. aligned trap;
  - 2. aligned redirect;
  - 3. pending entry;
  - 4. pc_out+4.
  - The selected value SHALL appear on pc_out the following cycle (one-cycle latency).
REQ-022 An aligned request arriving while pc_valid=1 and fetch_ready=0 SHALL be stored in a single pending entry (address plus is_trap flag), and the FSM SHALL go to HOLD.
REQ-023 Pending overwrite rules:
  - a trap overwrites any pending entry;
  - a redirect overwrites only a pending redirect;
  - a redirect never overwrites a pending trap.
REQ-024 In HOLD, the next handshake SHALL load the pending address (unless a new aligned trap, or a redirect with no pending trap, arrives that cycle), clear the entry, and return to RUN.
REQ-025 Sequential increment SHALL be pc_out+4 modulo 2^XLEN; {XLEN{1'b1}}-3 wraps to 0.
REQ-026 fetch_count SHALL increment by 1 on each handshake and wrap from 2^CNT_W-1 to 0.
REQ-027 misalign_err SHALL be registered and SHALL never be high for two consecutive cycles unless a misaligned target is presented on consecutive cycles.

Reset
REQ-028 reset=1 SHALL immediately, without waiting for a clock edge, set:
  - pc_out=RESET_VECTOR, pc_valid=0, misalign_err=0;
  - misalign_addr=0, fetch_count=0;
  - pending entry cleared, state=BOOT.
REQ-029 Reset asserted mid-HOLD SHALL discard the pending entry; after deassertion the first fetch address SHALL be RESET_VECTOR, with no pending redirect applied.
REQ-030 Requests presented in BOOT SHALL be honoured per REQ-021, replacing RESET_VECTOR as the first valid pc_out.

Verification
REQ-031 Reset with RESET_VECTOR=0x1000, then fetch_ready=1 held -> pc_valid rises one cycle after reset release; pc_out sequence is 0x1000, 0x1004, 0x1008; fetch_count counts 1, 2, 3.
REQ-032 At pc_out=0x2000 with fetch_ready=0, pulse redirect to 0x3000, then raise fetch_ready 3 cycles later -> pc_out holds 0x2000 until the handshake, then shows 0x3000 the next cycle.
REQ-033 Same cycle: trap_valid (0x80) and redirect_valid (0x400) -> next pc_out=0x80. While stalled: trap 0x80 pending, then redirect 0x400 -> release yields 0x80.
REQ-034 Redirect target 0x1002 -> target dropped, pc_out continues sequentially; misalign_err high exactly one cycle with misalign_addr=0x1002.
REQ-035 XLEN=32, redirect to 0xFFFFFFFC, then fetch_ready=1 -> pc_out 0xFFFFFFFC then 0x00000000. Separately, preload fetch_count to 2^CNT_W-1 via handshakes (CNT_W=4) -> next handshake gives 0.
REQ-036 Assert reset during HOLD with a pending redirect to 0x500 -> after release pc_out=RESET_VECTOR, and 0x500 never appears on pc_out.
